// File: rtl/req_encoder_pkg.sv
// Shared sizing and state encoding for the request encoder.
package enc_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE, PRESENT} enc_state_t;
endpackage

// File: rtl/req_encoder_if.sv
// Valid/ready index channel from the encoder to its single consumer.
interface req_encoder_if;
  logic                      out_valid;
  logic                      out_ready;
  logic [enc_pkg::IDX_W-1:0] out_idx;

  modport master (output out_valid, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_idx, output out_ready);
endinterface

// File: rtl/req_encoder_prio_enc8.sv
// Lowest-set-bit finder: bit 0 has the highest priority.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Registered 8-to-3 request encoder: collects request strobes into a pending
// register and presents the lowest pending index on a valid/ready channel.
module req_encoder
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  req_encoder_if.master    out,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  enc_state_t       state;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;

  logic [N_REQ-1:0] dec_mask;
  logic [N_REQ-1:0] clr_mask;
  logic [N_REQ-1:0] cand;
  logic             hs;
  logic [IDX_W-1:0] idle_idx;
  logic             idle_any;
  logic [IDX_W-1:0] next_idx;
  logic             next_any;

  assign out.out_valid = valid_q;
  assign out.out_idx   = idx_q;

  assign hs = valid_q & out.out_ready;

  // Inline 3-to-8 decode of the presented index.
  always_comb begin
    dec_mask         = '0;
    dec_mask[idx_q]  = 1'b1;
  end

  assign clr_mask = hs ? dec_mask : '0;
  // Next candidate comes from the registered pending only; same-cycle
  // requests become selectable one cycle later.
  assign cand     = pending & ~dec_mask;

  prio_enc8 u_sel_idle (.req(pending), .idx(idle_idx), .any(idle_any));
  prio_enc8 u_sel_next (.req(cand),    .idx(next_idx), .any(next_any));

  // Pending/overflow bookkeeping and the IDLE/PRESENT controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      valid_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      // A request re-hitting the bit being cleared is a fresh request, not a merge.
      pending  <= (pending & ~clr_mask) | req_in;
      overflow <= |(req_in & pending & ~clr_mask);
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (idle_any) begin
            idx_q   <= idle_idx;
            valid_q <= 1'b1;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          // Index holds while stalled, even if a higher-priority request lands.
          if (out.out_ready) begin
            if (next_any) begin
              idx_q <= next_idx;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder.sv
// Scoreboard bench for req_encoder: a reference model predicts every cycle's
// outputs into a queue, a monitor pops and compares after each clock edge.
module tb_req_encoder;
  import enc_pkg::*;

  typedef struct {
    logic       valid;
    logic [2:0] idx;
    logic       chk_idx;
    logic [7:0] pend;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] pending;
  logic       overflow;

  req_encoder_if bus ();

  req_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (req_in),
    .out     (bus.master),
    .pending (pending),
    .overflow(overflow)
  );

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: pending set as a bit vector, presented index (-1 = none).
  logic [7:0] m_pend = '0;
  int         m_cur  = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model(input logic [7:0] r, input logic rdy, input logic rs, output exp_t e);
    logic [7:0] np;
    logic [7:0] tmp;
    bit         acc;
    int         nc;
    e.ovf     = 1'b0;
    e.chk_idx = 1'b0;
    if (rs) begin
      m_pend    = '0;
      m_cur     = -1;
      e.chk_idx = 1'b1;
    end else begin
      acc = (m_cur >= 0) && rdy;
      np  = m_pend;
      if (acc) np[m_cur] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (r[i]) begin
          if (m_pend[i] && !(acc && i == m_cur)) e.ovf = 1'b1;
          np[i] = 1'b1;
        end
      end
      if (m_cur < 0) nc = lowest(m_pend);
      else if (acc) begin
        tmp = m_pend;
        tmp[m_cur] = 1'b0;
        nc = lowest(tmp);
      end else nc = m_cur;
      m_pend = np;
      m_cur  = nc;
    end
    e.pend  = m_pend;
    e.valid = (m_cur >= 0);
    e.idx   = (m_cur >= 0) ? 3'(m_cur) : 3'd0;
    if (e.valid) e.chk_idx = 1'b1;
  endtask

  task automatic step(input logic [7:0] r, input logic rdy, input logic rs);
    exp_t e;
    @(negedge clk);
    req_in        = r;
    bus.out_ready = rdy;
    rst_n         = ~rs;
    model(r, rdy, rs, e);
    q.push_back(e);
  endtask

  // Monitor: compare each registered output just after the edge it was predicted for.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_valid", int'(bus.out_valid), int'(e.valid));
      if (e.chk_idx) chk("out_idx", int'(bus.out_idx), int'(e.idx));
      chk("pending", int'(pending), int'(e.pend));
      chk("overflow", int'(overflow), int'(e.ovf));
    end
  end

  initial begin
    req_in        = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    step(8'h00, 1'b0, 1'b1);
    // Reset after saturating requests.
    repeat (3) step(8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b0);

    // Single request: index 5 two cycles later.
    step(8'h20, 1'b1, 1'b0);
    repeat (4) step(8'h00, 1'b1, 1'b0);

    // Priority and back-to-back: 0, 2, 7.
    step(8'h85, 1'b1, 1'b0);
    repeat (6) step(8'h00, 1'b1, 1'b0);

    // Stall stability: index 4 held while a higher-priority request arrives.
    step(8'h10, 1'b0, 1'b0);
    repeat (2) step(8'h00, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b0);
    repeat (2) step(8'h00, 1'b0, 1'b0);
    repeat (4) step(8'h00, 1'b1, 1'b0);

    // Overflow on a stalled bit, then a re-request during its handshake.
    step(8'h08, 1'b0, 1'b0);
    repeat (2) step(8'h00, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h08, 1'b1, 1'b0);
    repeat (4) step(8'h00, 1'b1, 1'b0);

    // Reset mid-transfer: indices 2 and 3 must vanish.
    step(8'h0C, 1'b0, 1'b0);
    repeat (2) step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    repeat (4) step(8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      step(r, 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
    end
    repeat (10) step(8'h00, 1'b1, 1'b0);

    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_encoder.md
# req_encoder

Registered 8-to-3 request encoder: the inverse of the team's 3-to-8 one-hot decode path. Collects up to eight request strobes into a pending register and selects the lowest-numbered pending request. Presents that request as a 3-bit index on a valid/ready output and clears the request once the index is accepted. Sits between per-source request lines (interrupts, arbitration requests) and a single consumer that takes one index at a time.

## Interface
- `N_REQ`, default 8: number of request lines; fixed at 8 for this revision.
- `IDX_W`, default 3: index width, `$clog2(N_REQ)`; derived, never overridden.
- `clk` input 1: single clock, all logic rising-edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req_in` input 8: request strobes, sampled every cycle; a 1 sets the matching pending bit.
- `out_valid` output 1: `out_idx` holds a pending request.
- `out_ready` input 1: consumer accepts `out_idx` when high together with `out_valid`.
- `out_idx` output 3: index of the presented request; bit 0 has highest priority.
- `pending` output 8: current pending register, including the bit being presented.
- `overflow` output 1: one-cycle pulse; a request hit an already-pending bit and was merged.

## Operation
- **Reset** (`rst_n`=0 at a clock edge):
  - `pending`=8'h00, state IDLE, `out_valid`=0, `out_idx`=3'd0, `overflow`=0.
  - Reset mid-handshake drops the pending bits and the presented index; nothing is replayed.
- **Pending update:** `pending_next = (pending & ~clr_mask) | req_in`.
  - `clr_mask` is the one-hot of `out_idx` when `out_valid && out_ready`, else 0.
  - If `req_in` re-asserts the bit being cleared in the same cycle, the new request wins and the bit stays set. This does not raise `overflow`.
- **Overflow:** for any bit with `req_in`=1, `pending`=1 and that bit not cleared this cycle, `overflow`=1 on the next cycle. The request is merged, not counted.
- **State machine (2 states):**
  - IDLE:
    - `out_valid`=0.
    - If `pending`≠0, load `out_idx` with the lowest set bit of `pending` and go to PRESENT.
    - Selection uses the registered `pending`, not `req_in`.
  - PRESENT:
    - `out_valid`=1. `out_idx` holds stable while `out_ready`=0, even if a higher-priority request arrives.
    - On handshake, the candidate set is `pending & ~onehot(out_idx)`, using the registered `pending`. Same-cycle `req_in` is excluded.
    - If the candidate set is non-zero, load its lowest set bit into `out_idx` and stay in PRESENT. This gives back-to-back transfers.
    - Otherwise go to IDLE.
- **Priority:** fixed, with index 0 highest. Starvation of high indices under continuous low-index traffic is accepted behaviour.
- `out_ready` is ignored while `out_valid`=0.

## Timing
- **Latency:** `req_in` high in cycle t → `pending` bit set in t+1 → `out_valid`=1 with `out_idx` in t+2 (from IDLE).
- **Throughput:** one index per cycle while the candidate set stays non-empty and `out_ready`=1.
- A handshake in cycle t clears the pending bit in t+1. A request arriving in t is first selectable in t+1.
- `out_valid`, `out_idx`, `pending` and `overflow` are all registered. There is no combinational path from `req_in` or `out_ready` to any output.

## Structure
- Package `enc_pkg`:
  - `localparam N_REQ=8`, `IDX_W=3`.
  - `typedef enum logic {IDLE, PRESENT} enc_state_t`.
- Sub-module `prio_enc8`: combinational lowest-set-bit finder.
  - Ports: 8-bit input, 3-bit index output, `any` flag.
  - Instantiated twice: IDLE selection and PRESENT next-candidate selection.
- The one-hot clear mask is an inline 3-to-8 decode of `out_idx`.

## Test plan
- **Reset:** drive `req_in`=8'hFF for 3 cycles, then `rst_n`=0 for 1 cycle → `pending`=0, `out_valid`=0, `out_idx`=0, `overflow`=0 on the following cycle.
- **Single request:** pulse `req_in`=8'h20 at t with `out_ready`=1 → `out_valid`=1 and `out_idx`=5 at t+2; `pending`=0 at t+3; `out_valid`=0 at t+3.
- **Priority and back-to-back:** pulse `req_in`=8'h85 with `out_ready` held 1 → `out_idx` sequence 0, 2, 7 on consecutive cycles, then `out_valid`=0.
- **Stall stability:** `pending`=8'h10 presented with `out_ready`=0, then `req_in`=8'h01 → `out_idx` stays 4 until `out_ready`=1; the next index is 0.
- **Overflow:** `pending` bit 3 set and not accepted, pulse `req_in`=8'h08 → `overflow`=1 for exactly one cycle and `pending` unchanged. The same pulse during bit 3's handshake cycle → `overflow`=0 and bit 3 re-presented later.
- **Reset mid-transfer:** `out_valid`=1, `out_idx`=2, `pending`=8'h0C, assert `rst_n`=0 → all outputs return to reset values the next cycle, and index 2 and index 3 are never presented.
